// File: rtl/rt_ibex_pcs_stack_if.sv
// Request/restore bundle between the controller/CSR block and the context-save stack.
// The controller side uses the master modport, the stack uses the slave modport.
interface rt_ibex_pcs_stack_if #(
  parameter int NrSavedRegs   = 9,
  parameter int DataWidth     = 32,
  parameter int Depth         = 8,
  parameter int IrqLevelWidth = 8
);
  localparam int CntWidth = $clog2(Depth + 1);

  logic                                  push_i;
  logic [IrqLevelWidth-1:0]              irq_level_i;
  logic                                  pop_i;
  logic [NrSavedRegs-1:0][DataWidth-1:0] store_data_i;
  logic                                  clear_err_i;
  logic [NrSavedRegs-1:0][DataWidth-1:0] restore_data_o;
  logic [IrqLevelWidth-1:0]              restore_level_o;
  logic                                  restore_en_o;
  logic                                  tail_chain_o;
  logic                                  busy_o;
  logic [CntWidth-1:0]                   count_o;
  logic                                  full_o;
  logic                                  empty_o;
  logic                                  overflow_o;
  logic                                  underflow_o;

  modport master (
    output push_i, irq_level_i, pop_i, store_data_i, clear_err_i,
    input  restore_data_o, restore_level_o, restore_en_o, tail_chain_o, busy_o,
           count_o, full_o, empty_o, overflow_o, underflow_o
  );

  modport slave (
    input  push_i, irq_level_i, pop_i, store_data_i, clear_err_i,
    output restore_data_o, restore_level_o, restore_en_o, tail_chain_o, busy_o,
           count_o, full_o, empty_o, overflow_o, underflow_o
  );
endinterface

// File: rtl/rt_ibex_pcs_stack.sv
// Hardware context-save LIFO for nested interrupts: slot 0 is always the newest frame,
// pushes shift older frames down, restores shift them back up.
module rt_ibex_pcs_stack #(
  parameter int NrSavedRegs   = 9,
  parameter int DataWidth     = 32,
  parameter int Depth         = 8,
  parameter int IrqLevelWidth = 8
) (
  input logic                clk_i,
  input logic                rst_i,
  rt_ibex_pcs_stack_if.slave bus
);
  localparam int CntWidth = $clog2(Depth + 1);

  typedef enum logic [1:0] {IDLE, STORE, RESTORE} state_e;
  typedef logic [NrSavedRegs-1:0][DataWidth-1:0] frame_t;

  state_e                   state_q, state_d;
  frame_t                   data_q  [Depth];
  frame_t                   data_d  [Depth];
  logic [IrqLevelWidth-1:0] level_q [Depth];
  logic [IrqLevelWidth-1:0] level_d [Depth];
  logic [CntWidth-1:0]      count_q, count_d;
  logic                     ovf_q, ovf_d;
  logic                     und_q, und_d;
  logic                     tail_q, tail_d;
  logic                     full;

  assign full = (count_q == CntWidth'(Depth));

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    level_d = level_q;
    count_d = count_q;
    // A new error event overrides a simultaneous clear.
    ovf_d   = ovf_q & ~bus.clear_err_i;
    und_d   = und_q & ~bus.clear_err_i;
    tail_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.push_i && bus.pop_i) begin
          tail_d = 1'b1;
        end else if (bus.push_i) begin
          state_d = STORE;
        end else if (bus.pop_i) begin
          if (count_q == '0) und_d = 1'b1;
          else               state_d = RESTORE;
        end
      end
      STORE: begin
        for (int i = Depth - 1; i > 0; i--) begin
          data_d[i]  = data_q[i-1];
          level_d[i] = level_q[i-1];
        end
        data_d[0]  = bus.store_data_i;
        level_d[0] = bus.irq_level_i;
        // When full the shift has already dropped the oldest frame.
        if (full) ovf_d   = 1'b1;
        else      count_d = count_q + CntWidth'(1);
        state_d = IDLE;
      end
      RESTORE: begin
        for (int i = 0; i < Depth - 1; i++) begin
          data_d[i]  = data_q[i+1];
          level_d[i] = level_q[i+1];
        end
        data_d[Depth-1]  = '0;
        level_d[Depth-1] = '0;
        count_d = count_q - CntWidth'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      for (int i = 0; i < Depth; i++) begin
        data_q[i]  <= '0;
        level_q[i] <= '0;
      end
      count_q <= '0;
      ovf_q   <= 1'b0;
      und_q   <= 1'b0;
      tail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      level_q <= level_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      und_q   <= und_d;
      tail_q  <= tail_d;
    end
  end

  assign bus.restore_data_o  = data_q[0];
  assign bus.restore_level_o = level_q[0];
  assign bus.restore_en_o    = (state_q == RESTORE);
  assign bus.tail_chain_o    = tail_q;
  assign bus.busy_o          = (state_q != IDLE);
  assign bus.count_o         = count_q;
  assign bus.full_o          = full;
  assign bus.empty_o         = (count_q == '0);
  assign bus.overflow_o      = ovf_q;
  assign bus.underflow_o     = und_q;
endmodule

// File: tb/tb_rt_ibex_pcs_stack.sv
// Directed and randomized checks of the context-save stack against a queue-based model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_rt_ibex_pcs_stack;
  localparam int NR    = 9;
  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int LW    = 8;
  localparam int FW    = NR * DW;

  typedef struct {
    logic [FW-1:0] d;
    logic [LW-1:0] l;
  } frame_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rt_ibex_pcs_stack_if #(.NrSavedRegs(NR), .DataWidth(DW), .Depth(DEPTH), .IrqLevelWidth(LW)) bus ();

  rt_ibex_pcs_stack #(.NrSavedRegs(NR), .DataWidth(DW), .Depth(DEPTH), .IrqLevelWidth(LW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int     vectors     = 0;
  int     miscompares = 0;
  frame_t mq[$];
  logic   m_ovf = 1'b0;
  logic   m_und = 1'b0;

  task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic exp_tail);
    logic [FW-1:0] ed;
    logic [LW-1:0] el;
    ed = (mq.size() > 0) ? mq[0].d : '0;
    el = (mq.size() > 0) ? mq[0].l : '0;
    check({tag, ".count"}, FW'(bus.count_o),         FW'(mq.size()));
    check({tag, ".full"},  FW'(bus.full_o),          FW'(mq.size() == DEPTH));
    check({tag, ".empty"}, FW'(bus.empty_o),         FW'(mq.size() == 0));
    check({tag, ".busy"},  FW'(bus.busy_o),          '0);
    check({tag, ".ren"},   FW'(bus.restore_en_o),    '0);
    check({tag, ".tail"},  FW'(bus.tail_chain_o),    FW'(exp_tail));
    check({tag, ".ovf"},   FW'(bus.overflow_o),      FW'(m_ovf));
    check({tag, ".und"},   FW'(bus.underflow_o),     FW'(m_und));
    check({tag, ".data"},  FW'(bus.restore_data_o),  ed);
    check({tag, ".lvl"},   FW'(bus.restore_level_o), FW'(el));
  endtask

  function automatic logic [FW-1:0] rnd_frame();
    logic [FW-1:0] f;
    for (int i = 0; i < NR; i++) f[i*DW +: DW] = $urandom();
    return f;
  endfunction

  function automatic logic [FW-1:0] const_frame(input int k);
    logic [FW-1:0] f;
    for (int i = 0; i < NR; i++) f[i*DW +: DW] = DW'(k);
    return f;
  endfunction

  task automatic do_push(input logic [FW-1:0] d, input logic [LW-1:0] l, input bit clr, input bit hold);
    bus.push_i = 1'b1; bus.pop_i = 1'b0; bus.store_data_i = d; bus.irq_level_i = l;
    bus.clear_err_i = clr;
    @(negedge clk);
    if (clr) begin m_ovf = 1'b0; m_und = 1'b0; end
    check("push.busy", FW'(bus.busy_o), FW'(1'b1));
    check("push.ren",  FW'(bus.restore_en_o), '0);
    bus.clear_err_i = 1'b0;
    bus.push_i = hold;
    @(negedge clk);
    if (mq.size() == DEPTH) begin
      void'(mq.pop_back());
      m_ovf = 1'b1;
    end
    mq.push_front('{d: d, l: l});
    bus.push_i = 1'b0;
    check_state("push", 1'b0);
    if (hold) begin
      @(negedge clk);
      check_state("push.hold", 1'b0);
    end
    $display("push lvl=%0d count=%0d", l, bus.count_o);
  endtask

  task automatic do_pop(input bit clr);
    bus.pop_i = 1'b1; bus.push_i = 1'b0; bus.clear_err_i = clr;
    @(negedge clk);
    if (clr) m_ovf = 1'b0;
    if (mq.size() == 0) begin
      m_und = 1'b1;
      bus.pop_i = 1'b0; bus.clear_err_i = 1'b0;
      check_state("pop.empty", 1'b0);
      $display("pop on empty und=%0b", bus.underflow_o);
    end else begin
      if (clr) m_und = 1'b0;
      check("pop.busy", FW'(bus.busy_o),          FW'(1'b1));
      check("pop.ren",  FW'(bus.restore_en_o),    FW'(1'b1));
      check("pop.data", FW'(bus.restore_data_o),  mq[0].d);
      check("pop.lvl",  FW'(bus.restore_level_o), FW'(mq[0].l));
      $display("pop lvl=%0d word0=%0h", bus.restore_level_o, bus.restore_data_o[0]);
      bus.pop_i = 1'b0; bus.clear_err_i = 1'b0;
      @(negedge clk);
      void'(mq.pop_front());
      check_state("pop", 1'b0);
    end
  endtask

  task automatic do_tail(input bit clr);
    bus.push_i = 1'b1; bus.pop_i = 1'b1; bus.clear_err_i = clr;
    bus.store_data_i = rnd_frame(); bus.irq_level_i = LW'($urandom());
    @(negedge clk);
    if (clr) begin m_ovf = 1'b0; m_und = 1'b0; end
    bus.push_i = 1'b0; bus.pop_i = 1'b0; bus.clear_err_i = 1'b0;
    check_state("tail", 1'b1);
    @(negedge clk);
    check_state("tail.after", 1'b0);
    $display("tail-chain count=%0d", bus.count_o);
  endtask

  task automatic do_idle(input bit clr);
    bus.clear_err_i = clr;
    @(negedge clk);
    if (clr) begin m_ovf = 1'b0; m_und = 1'b0; end
    bus.clear_err_i = 1'b0;
    check_state("idle", 1'b0);
    $display("idle clr=%0b ovf=%0b und=%0b", clr, bus.overflow_o, bus.underflow_o);
  endtask

  initial begin
    rst = 1'b1;
    bus.push_i = 1'b0; bus.pop_i = 1'b0; bus.clear_err_i = 1'b0;
    bus.store_data_i = '0; bus.irq_level_i = '0;
    @(negedge clk);
    @(negedge clk);
    check_state("reset", 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check_state("reset.rel", 1'b0);

    // Three nested interrupts, then unwind.
    do_push(rnd_frame(), 8'd3, 1'b0, 1'b0);
    do_push(rnd_frame(), 8'd5, 1'b0, 1'b0);
    do_push(rnd_frame(), 8'd7, 1'b0, 1'b0);
    repeat (3) do_pop(1'b0);

    // Overflow drops the oldest frame.
    for (int k = 1; k <= 9; k++) do_push(const_frame(k), LW'(k), 1'b0, 1'b0);
    check("ovf.count", FW'(bus.count_o), FW'(DEPTH));
    repeat (8) do_pop(1'b0);
    do_idle(1'b1);

    // Underflow, clear, and clear colliding with a new underflow.
    do_pop(1'b0);
    do_idle(1'b1);
    do_pop(1'b0);
    do_pop(1'b1);
    do_idle(1'b1);

    // Tail-chain with two frames stored.
    do_push(rnd_frame(), 8'd2, 1'b0, 1'b0);
    do_push(rnd_frame(), 8'd4, 1'b0, 1'b0);
    do_tail(1'b0);

    // Push held through STORE stores once.
    do_push(rnd_frame(), 8'd9, 1'b0, 1'b1);
    while (mq.size() > 0) do_pop(1'b0);

    // Reset during RESTORE with four frames.
    repeat (4) do_push(rnd_frame(), LW'($urandom()), 1'b0, 1'b0);
    bus.pop_i = 1'b1;
    @(negedge clk);
    check("rstmid.ren", FW'(bus.restore_en_o), FW'(1'b1));
    rst = 1'b1;
    bus.pop_i = 1'b0;
    #1;
    mq.delete(); m_ovf = 1'b0; m_und = 1'b0;
    check_state("rstmid", 1'b0);
    $display("reset mid-restore count=%0d", bus.count_o);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_state("rstmid.rel", 1'b0);

    // Random operation mix.
    for (int n = 0; n < 300; n++) begin
      int op;
      bit clr;
      op  = $urandom_range(0, 9);
      clr = ($urandom_range(0, 7) == 0);
      if (op < 5)       do_push(rnd_frame(), LW'($urandom()), clr, bit'($urandom_range(0, 1)));
      else if (op < 8)  do_pop(clr);
      else if (op == 8) do_tail(clr);
      else              do_idle(clr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/rt_ibex_pcs_stack.md
Name: rt_ibex_pcs_stack

Overview:
Parametrised hardware context-save stack for nested interrupts in the RT-Ibex core. On interrupt acknowledge it pushes a frame of NrSavedRegs registers plus the interrupt level. On the cycle before mret it pops the newest frame for register-file restore. Compared with the first-generation shift LIFO it adds:
- configurable depth independent of level width
- occupancy count, full and empty flags
- sticky overflow and underflow errors
- level tagging of each frame
- tail-chain handling
It sits between the controller/CSR block and the register file.

Parameters:
NrSavedRegs, 9, registers per frame.
DataWidth, 32, bits per register.
Depth, 8, frames held (>=2).
IrqLevelWidth, 8, width of interrupt level tag.
CntWidth, $clog2(Depth+1), occupancy counter width (derived, localparam).

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
push_i  in  1  irq acknowledged; request to save context
irq_level_i  in  IrqLevelWidth  level of acknowledged irq, tagged onto frame
pop_i  in  1  next instruction is mret; request to restore
store_data_i  in  NrSavedRegs x DataWidth  registers to save
restore_data_o  out  NrSavedRegs x DataWidth  top frame registers
restore_level_o  out  IrqLevelWidth  top frame level tag
restore_en_o  out  1  one-cycle restore strobe
tail_chain_o  out  1  one-cycle pulse: push and pop merged
busy_o  out  1  FSM not IDLE
count_o  out  CntWidth  frames stored
full_o  out  1  count_o == Depth
empty_o  out  1  count_o == 0
overflow_o  out  1  sticky: push while full
underflow_o  out  1  sticky: pop while empty
clear_err_i  in  1  clears both sticky errors

Behaviour:
- Reset (async on rst_i high):
  - FSM goes to IDLE.
  - All frames, levels and count clear to 0; errors clear to 0.
  - All outputs are 0 except empty_o=1.
- FSM states are IDLE, STORE and RESTORE.
- Requests are only sampled in IDLE. push_i and pop_i are ignored while busy_o=1, with no error and no effect.
- IDLE, push_i=1 and pop_i=0 -> STORE:
  - During the STORE cycle, store_data_i and irq_level_i are sampled into slot 0 and older frames shift down one slot.
  - count increments at the end of STORE.
  - The next state is IDLE, so push-to-stored latency is 2 cycles.
- STORE when full:
  - The oldest frame (slot Depth-1) is discarded, count stays Depth and overflow_o sets.
- IDLE, pop_i=1, push_i=0 and not empty -> RESTORE:
  - During the RESTORE cycle, restore_en_o=1 and restore_data_o/restore_level_o show slot 0.
  - At the end of the cycle, frames shift up, slot Depth-1 is zeroed, count decrements, and the FSM returns to IDLE.
- IDLE, pop_i=1, empty: stay IDLE, restore_en_o stays 0, underflow_o sets the next cycle.
- IDLE, push_i=1 and pop_i=1 (tail-chain): stay IDLE and tail_chain_o=1 for 1 cycle. Stack contents, count and level tags are unchanged, because the new handler reuses the saved context.
- restore_data_o/restore_level_o always reflect slot 0, which is zero when empty.
- Sticky error precedence: clear_err_i and a new error event in the same cycle -> the error wins (stays/becomes 1).
- full_o, empty_o and count_o are registered-state derived, with no combinational path from inputs.
- Reset mid-STORE/RESTORE aborts the operation with no partial shift, and the block comes out of reset empty.

Test Plan:
- Push frames A(lvl 3), B(lvl 5), C(lvl 7), then pop 3 times -> restore_en_o pulses show C/7, B/5, A/3; count_o goes 3→0; empty_o=1.
- Depth=8: 9 pushes with frame k=k → overflow_o=1, count_o=8; 8 pops yield 9..2; frame 1 is lost.
- Pop when empty → restore_en_o stays 0, underflow_o=1. Then clear_err_i=1 → underflow_o=0 the next cycle.
- With 2 frames stored, push_i=pop_i=1 in IDLE → tail_chain_o=1 for 1 cycle, count_o stays 2, top frame unchanged.
- push_i held 1 during the STORE cycle → only one frame is stored (count +1); busy_o=1 exactly 1 cycle.
- rst_i asserted during the RESTORE cycle with count 4 → count_o=0, restore_en_o=0, all outputs at reset values.
